// File: rtl/adpll_cfg_seq.sv
// ADPLL configure-and-lock sequencer.
// Drives the ADPLL register block over a simple valid/ready CPU bus:
// disable, program FCW and mode, enable, poll the lock flag, read the
// saturation flag, then report the result flags.
module adpll_cfg_seq #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned FCW_W    = 26,
    parameter int unsigned POLL_GAP = 8,
    parameter int unsigned NPOLL_W  = 16,
    // Register map, matching the ADPLL register block defines.
    parameter logic [ADDR_W-1:0] ADDR_ADPLL_EN   = ADDR_W'(5'h00),
    parameter logic [ADDR_W-1:0] ADDR_FCW        = ADDR_W'(5'h02),
    parameter logic [ADDR_W-1:0] ADDR_ADPLL_MODE = ADDR_W'(5'h03),
    parameter logic [ADDR_W-1:0] ADDR_ADPLL_LOCK = ADDR_W'(5'h08),
    parameter logic [ADDR_W-1:0] ADDR_ADPLL_SAT  = ADDR_W'(5'h09)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FCW_W-1:0]   fcw_in,
    input  logic [1:0]         mode_in,
    input  logic [NPOLL_W-1:0] max_polls,
    output logic               valid,
    output logic [ADDR_W-1:0]  address,
    output logic [31:0]        wdata,
    output logic               wstrb,
    input  logic [31:0]        rdata,
    input  logic               ready,
    output logic               busy,
    output logic               done,
    output logic               locked,
    output logic               sat,
    output logic               timeout,
    output logic               bus_err
);

    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    typedef enum logic [3:0] {
        StIdle,
        StWrDis,
        StWrFcw,
        StWrMode,
        StWrEn,
        StRdLock,
        StGap,
        StRdSat,
        StFin
    } state_e;

    state_e             state;
    logic [FCW_W-1:0]   fcw_q;
    logic [1:0]         mode_q;
    logic [NPOLL_W-1:0] limit_q;
    logic [NPOLL_W-1:0] poll_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [1:0]         wd_cnt;

    logic               in_txn;
    logic               rd_err;
    logic [NPOLL_W-1:0] poll_nxt;

    // Decode of bus-transaction states and read-side error/poll helpers.
    always_comb begin
        in_txn   = (state == StWrDis) || (state == StWrFcw) || (state == StWrMode) ||
                   (state == StWrEn)  || (state == StRdLock) || (state == StRdSat);
        rd_err   = (rdata == 32'hFFFF_FFFF);
        poll_nxt = poll_cnt + NPOLL_W'(1);
    end

    // Sequencer FSM with registered bus outputs and result flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= StIdle;
            fcw_q    <= '0;
            mode_q   <= '0;
            limit_q  <= '0;
            poll_cnt <= '0;
            gap_cnt  <= '0;
            wd_cnt   <= '0;
            valid    <= 1'b0;
            address  <= '0;
            wdata    <= '0;
            wstrb    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            locked   <= 1'b0;
            sat      <= 1'b0;
            timeout  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (in_txn && valid) begin
                // ISSUE lasts one cycle; hold address/data while waiting.
                valid  <= 1'b0;
                wd_cnt <= '0;
            end else if (in_txn && !ready) begin
                // Four WAIT cycles without ready means the responder is gone.
                if (wd_cnt == 2'd3) begin
                    bus_err <= 1'b1;
                    done    <= 1'b1;
                    address <= '0;
                    wdata   <= '0;
                    wstrb   <= 1'b0;
                    state   <= StFin;
                end else begin
                    wd_cnt <= wd_cnt + 2'd1;
                end
            end else begin
                case (state)
                    StIdle: begin
                        if (start) begin
                            fcw_q    <= fcw_in;
                            mode_q   <= mode_in;
                            limit_q  <= (max_polls == '0) ? NPOLL_W'(1) : max_polls;
                            poll_cnt <= '0;
                            locked   <= 1'b0;
                            sat      <= 1'b0;
                            timeout  <= 1'b0;
                            bus_err  <= 1'b0;
                            busy     <= 1'b1;
                            valid    <= 1'b1;
                            address  <= ADDR_ADPLL_EN;
                            wdata    <= 32'd0;
                            wstrb    <= 1'b1;
                            state    <= StWrDis;
                        end
                    end
                    StWrDis: begin
                        valid   <= 1'b1;
                        address <= ADDR_FCW;
                        wdata   <= 32'(fcw_q);
                        wstrb   <= 1'b1;
                        state   <= StWrFcw;
                    end
                    StWrFcw: begin
                        valid   <= 1'b1;
                        address <= ADDR_ADPLL_MODE;
                        wdata   <= {30'd0, mode_q};
                        wstrb   <= 1'b1;
                        state   <= StWrMode;
                    end
                    StWrMode: begin
                        valid   <= 1'b1;
                        address <= ADDR_ADPLL_EN;
                        wdata   <= 32'd1;
                        wstrb   <= 1'b1;
                        state   <= StWrEn;
                    end
                    StWrEn: begin
                        valid   <= 1'b1;
                        address <= ADDR_ADPLL_LOCK;
                        wdata   <= 32'd0;
                        wstrb   <= 1'b0;
                        state   <= StRdLock;
                    end
                    StRdLock: begin
                        if (rd_err) begin
                            // All-ones read back means the address did not decode.
                            bus_err <= 1'b1;
                            done    <= 1'b1;
                            address <= '0;
                            wdata   <= '0;
                            wstrb   <= 1'b0;
                            state   <= StFin;
                        end else if (rdata[0]) begin
                            locked  <= 1'b1;
                            valid   <= 1'b1;
                            address <= ADDR_ADPLL_SAT;
                            wdata   <= 32'd0;
                            wstrb   <= 1'b0;
                            state   <= StRdSat;
                        end else begin
                            poll_cnt <= poll_nxt;
                            if (poll_nxt == limit_q) begin
                                timeout <= 1'b1;
                                valid   <= 1'b1;
                                address <= ADDR_ADPLL_SAT;
                                wdata   <= 32'd0;
                                wstrb   <= 1'b0;
                                state   <= StRdSat;
                            end else if (POLL_GAP == 0) begin
                                valid <= 1'b1;
                                state <= StRdLock;
                            end else begin
                                gap_cnt <= '0;
                                state   <= StGap;
                            end
                        end
                    end
                    StGap: begin
                        if (gap_cnt == GAP_LAST) begin
                            valid   <= 1'b1;
                            address <= ADDR_ADPLL_LOCK;
                            wdata   <= 32'd0;
                            wstrb   <= 1'b0;
                            state   <= StRdLock;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    StRdSat: begin
                        if (rd_err) begin
                            bus_err <= 1'b1;
                            sat     <= 1'b0;
                        end else begin
                            sat <= rdata[0];
                        end
                        done    <= 1'b1;
                        address <= '0;
                        wdata   <= '0;
                        wstrb   <= 1'b0;
                        state   <= StFin;
                    end
                    StFin: begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adpll_cfg_seq.sv
// Directed bench for adpll_cfg_seq with a ready = valid-delayed-by-one responder.
module tb_adpll_cfg_seq;

    localparam logic [4:0] A_EN   = 5'h00;
    localparam logic [4:0] A_FCW  = 5'h02;
    localparam logic [4:0] A_MODE = 5'h03;
    localparam logic [4:0] A_LOCK = 5'h08;
    localparam logic [4:0] A_SAT  = 5'h09;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [25:0] fcw_in;
    logic [1:0]  mode_in;
    logic [15:0] max_polls;
    logic        valid;
    logic [4:0]  address;
    logic [31:0] wdata;
    logic        wstrb;
    logic [31:0] rdata;
    logic        ready = 1'b0;
    logic        busy;
    logic        done;
    logic        locked;
    logic        sat;
    logic        timeout;
    logic        bus_err;

    // Responder controls
    logic lock_val  = 1'b0;
    logic lock_ones = 1'b0;
    logic sat_val   = 1'b0;
    logic drop_fcw  = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    int ecnt     = 0;
    int e0       = 0;
    int base     = 0;
    int d0       = 0;
    int log_n    = 0;
    int done_cnt = 0;
    logic [4:0]  log_addr [256];
    logic [31:0] log_data [256];
    logic        log_we   [256];
    int          log_cyc  [256];

    adpll_cfg_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fcw_in    (fcw_in),
        .mode_in   (mode_in),
        .max_polls (max_polls),
        .valid     (valid),
        .address   (address),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .rdata     (rdata),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .locked    (locked),
        .sat       (sat),
        .timeout   (timeout),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ecnt  <= ecnt + 1;
        ready <= valid && !(drop_fcw && address == A_FCW);
    end

    always_comb begin
        rdata = 32'd0;
        if (address == A_LOCK) rdata = lock_ones ? 32'hFFFF_FFFF : {31'd0, lock_val};
        else if (address == A_SAT) rdata = {31'd0, sat_val};
    end

    // Bus and done-pulse log, sampled mid-cycle.
    always @(negedge clk) begin
        if (valid && log_n < 256) begin
            log_addr[log_n] <= address;
            log_data[log_n] <= wdata;
            log_we[log_n]   <= wstrb;
            log_cyc[log_n]  <= ecnt - e0;
            log_n           <= log_n + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_valid"}, 32'(valid), 0);
        check({pfx, "_addr"}, 32'(address), 0);
        check({pfx, "_wdata"}, wdata, 0);
        check({pfx, "_wstrb"}, 32'(wstrb), 0);
        check({pfx, "_busy"}, 32'(busy), 0);
        check({pfx, "_done"}, 32'(done), 0);
        check({pfx, "_flags"}, {28'd0, locked, sat, timeout, bus_err}, 0);
    endtask

    // Pulse start so it is sampled at the edge that ends cycle 0.
    task automatic start_seq(input logic [25:0] f, input logic [1:0] m, input logic [15:0] p);
        @(negedge clk);
        fcw_in    = f;
        mode_in   = m;
        max_polls = p;
        start     = 1'b1;
        @(posedge clk);
        e0   = ecnt;
        base = log_n;
        d0   = done_cnt;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", 32'(busy), 1);
    endtask

    task automatic wait_done(input string tag, output int dcyc);
        dcyc = -1;
        for (int k = 0; k < 300; k++) begin
            if (done) begin
                dcyc = ecnt - e0;
                break;
            end
            @(negedge clk);
        end
        if (dcyc < 0) check({tag, "_done_seen"}, 0, 1);
        @(negedge clk);
        check({tag, "_busy_fall"}, 32'(busy), 0);
    endtask

    task automatic wait_cyc(input int c);
        while ((ecnt - e0) < c) @(negedge clk);
    endtask

    task automatic check_txn(input string tag, input int idx, input logic [4:0] a,
                             input logic we, input logic [31:0] d, input int c);
        int i;
        i = base + idx;
        check($sformatf("%s_t%0d_addr", tag, idx), 32'(log_addr[i]), 32'(a));
        check($sformatf("%s_t%0d_we", tag, idx), 32'(log_we[i]), 32'(we));
        if (we) check($sformatf("%s_t%0d_data", tag, idx), log_data[i], d);
        check($sformatf("%s_t%0d_cyc", tag, idx), log_cyc[i], c);
    endtask

    task automatic run_nominal(input string tag);
        int dc;
        lock_val = 1'b1; lock_ones = 1'b0; sat_val = 1'b0; drop_fcw = 1'b0;
        start_seq(26'h2ABCDEF, 2'd2, 16'd5);
        wait_done(tag, dc);
        check({tag, "_done_cyc"}, dc, 13);
        check({tag, "_ntxn"}, log_n - base, 6);
        check_txn(tag, 0, A_EN,   1'b1, 32'd0,         1);
        check_txn(tag, 1, A_FCW,  1'b1, 32'h02ABCDEF,  3);
        check_txn(tag, 2, A_MODE, 1'b1, 32'd2,         5);
        check_txn(tag, 3, A_EN,   1'b1, 32'd1,         7);
        check_txn(tag, 4, A_LOCK, 1'b0, 32'd0,         9);
        check_txn(tag, 5, A_SAT,  1'b0, 32'd0,         11);
        check({tag, "_flags"}, {28'd0, locked, sat, timeout, bus_err}, 32'b1000);
    endtask

    initial begin
        int dc;
        int nlock;
        rst = 1'b0; start = 1'b1; fcw_in = '0; mode_in = '0; max_polls = '0;

        // Reset, with start held high throughout
        repeat (3) @(negedge clk);
        check_idle("rst");
        start = 1'b0;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_start_ignored", 32'(busy), 0);
        check("rst_no_bus", log_n, 0);

        // Lock on first read
        run_nominal("nom");

        // Lock never seen, three polls
        lock_val = 1'b0; sat_val = 1'b1;
        start_seq(26'h0000123, 2'd1, 16'd3);
        wait_done("tmo", dc);
        check("tmo_done_cyc", dc, 33);
        check("tmo_ntxn", log_n - base, 8);
        check_txn("tmo", 4, A_LOCK, 1'b0, 32'd0, 9);
        check_txn("tmo", 5, A_LOCK, 1'b0, 32'd0, 19);
        check_txn("tmo", 6, A_LOCK, 1'b0, 32'd0, 29);
        check_txn("tmo", 7, A_SAT,  1'b0, 32'd0, 31);
        check("tmo_flags", {28'd0, locked, sat, timeout, bus_err}, 32'b0110);
        repeat (10) @(negedge clk);
        check("tmo_one_done", done_cnt - d0, 1);

        // Responder silent on the FCW write
        drop_fcw = 1'b1; sat_val = 1'b0;
        start_seq(26'h3FFFFFF, 2'd3, 16'd4);
        wait_done("wdg", dc);
        check("wdg_done_cyc", dc, 8);
        check("wdg_flags", {28'd0, locked, sat, timeout, bus_err}, 32'b0001);
        repeat (10) @(negedge clk);
        check("wdg_ntxn", log_n - base, 2);
        check_txn("wdg", 1, A_FCW, 1'b1, 32'h03FFFFFF, 3);
        drop_fcw = 1'b0;

        // Lock read decodes to nothing
        lock_ones = 1'b1;
        start_seq(26'h0000001, 2'd0, 16'd4);
        wait_done("dec", dc);
        check("dec_done_cyc", dc, 11);
        check("dec_ntxn", log_n - base, 5);
        check("dec_flags", {28'd0, locked, sat, timeout, bus_err}, 32'b0001);
        lock_ones = 1'b0;

        // max_polls of zero behaves as one
        lock_val = 1'b0;
        start_seq(26'h0000042, 2'd1, 16'd0);
        wait_done("p0", dc);
        check("p0_done_cyc", dc, 13);
        nlock = 0;
        for (int i = base; i < log_n; i++) if (log_addr[i] == A_LOCK) nlock++;
        check("p0_lock_reads", nlock, 1);
        check("p0_flags", {28'd0, locked, sat, timeout, bus_err}, 32'b0010);

        // Restart attempt during RD_LOCK, then reset during GAP
        start_seq(26'h0000777, 2'd2, 16'd3);
        wait_cyc(9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(13);
        check("abort_no_restart", log_n - base, 5);
        check("abort_busy_gap", 32'(busy), 1);
        wait_cyc(14);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_idle("abort");
        repeat (20) @(negedge clk);
        check("abort_no_bus", log_n - base, 5);
        check("abort_no_done", done_cnt - d0, 0);
        run_nominal("rerun");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/adpll_cfg_seq.md
ADPLL_CFG_SEQ -- requirements
Module: adpll_cfg_seq

Interface
REQ-001 Parameter ADDR_W, default 5: width of the CPU-interface address bus; matches ADPLL_ADDR_W.
REQ-002 Parameter FCW_W, default 26: width of the frequency control word; matches FCWW.
REQ-003 Parameter POLL_GAP, default 8: idle cycles between a lock-read completion and the next lock read.
REQ-004 Parameter NPOLL_W, default 16: width of the poll-count limit.
REQ-005 Port clk, input, 1: single clock for all logic.
REQ-006 Port rst, input, 1: reset, synchronous and active-low.
REQ-007 Port start, input, 1: one-cycle request to run the configure-and-lock sequence.
REQ-008 Port fcw_in, input, FCW_W: FCW value to program.
REQ-009 Port mode_in, input, 2: adpll_mode value to program.
REQ-010 Port max_polls, input, NPOLL_W: maximum number of lock reads; a value of 0 is treated as 1.
REQ-011 Port valid, output, 1: bus request to the ADPLL register block.
REQ-012 Port address, output, ADDR_W: bus address.
REQ-013 Port wdata, output, 32: bus write data.
REQ-014 Port wstrb, output, 1: write strobe; 1 = write, 0 = read.
REQ-015 Port rdata, input, 32: combinational read data, valid while address is held.
REQ-016 Port ready, input, 1: the responder's registered copy of valid, arriving one cycle later.
REQ-017 Port busy, output, 1: sequence in progress.
REQ-018 Port done, output, 1: one-cycle pulse at the end of the sequence.
REQ-019 Port locked, sat, timeout, bus_err, outputs, 1 each: result flags, held until the next accepted start.

Function
REQ-020 Register addresses SHALL be the adpll_defines.v macros ADPLL_EN, FCW, ADPLL_MODE, ADPLL_LOCK and ADPLL_SAT.
REQ-021 Each transaction SHALL take two phases:
- ISSUE: valid=1 for exactly one cycle, with address, wdata and wstrb driven.
- WAIT: valid=0, with address, wdata and wstrb held until ready=1 is sampled.
REQ-022 Read data SHALL be captured from rdata in the cycle ready=1, while address is still held.
REQ-023 Bus watchdog: if ready is not seen within 4 cycles after ISSUE, set bus_err and go to FIN.
REQ-024 Any ready=1 seen outside WAIT SHALL be ignored.
REQ-025 FSM states and order: IDLE -> WR_DIS -> WR_FCW -> WR_MODE -> WR_EN -> RD_LOCK -> (GAP -> RD_LOCK)* -> RD_SAT -> FIN -> IDLE.
REQ-026 Write contents:
- WR_DIS writes ADPLL_EN = 0.
- WR_FCW writes FCW = zero-extended fcw_in.
- WR_MODE writes ADPLL_MODE = zero-extended mode_in.
- WR_EN writes ADPLL_EN = 1.
REQ-027 start SHALL be accepted only in IDLE; start while busy is ignored.
REQ-028 On an accepted start:
- fcw_in, mode_in and max_polls are latched.
- All result flags are cleared.
- busy rises in the next cycle.
REQ-029 RD_LOCK: if rdata == 32'hFFFFFFFF, set bus_err and go to FIN (address decode miss).
REQ-030 RD_LOCK: if rdata[0]=1, set locked and go to RD_SAT.
REQ-031 RD_LOCK: if rdata[0]=0, increment the poll counter.
- Counter reaches the latched limit: set timeout and go to RD_SAT.
- Otherwise: go to GAP.
REQ-032 GAP SHALL count exactly POLL_GAP cycles with valid=0, then return to RD_LOCK.
REQ-033 RD_SAT SHALL read ADPLL_SAT and set sat = rdata[0]; an all-ones rdata sets bus_err and sat=0.
REQ-034 FIN SHALL last one cycle with done=1; busy=0 from the following cycle.
REQ-035 Nominal latency, with start sampled at cycle 0 and lock on the first read:
- WR_DIS valid at cycle 1; WR_FCW at 3; WR_MODE at 5; WR_EN at 7.
- RD_LOCK valid at 9; RD_SAT valid at 11.
- done at 13.
REQ-036 The sequence never writes ADPLL_SOFT_RST or the loop-gain registers.

Reset
REQ-037 When rst=0 at a clock edge, the FSM SHALL go to IDLE and valid, wstrb, address, wdata, busy, done, locked, sat, timeout, bus_err and the counters SHALL all be 0.
REQ-038 Reset asserted mid-transaction SHALL abort the sequence with no further bus activity.
REQ-039 start sampled together with rst=0 SHALL be ignored.

Verification
REQ-040 Responder model (ready = valid delayed 1), lock=1 at the first read, sat=0, start at cycle 0 -> four writes (EN=0, FCW=fcw_in, MODE, EN=1), then reads at cycles 9 and 11; done at 13; locked=1, timeout=0.
REQ-041 Lock held 0, max_polls=3, POLL_GAP=8 -> exactly 3 lock reads spaced 8 idle cycles apart, then a SAT read; timeout=1, locked=0, one done pulse.
REQ-042 Responder never raises ready on WR_FCW -> bus_err=1 four cycles after ISSUE, FIN, no further valid.
REQ-043 rdata = 32'hFFFFFFFF on the lock read -> bus_err=1, locked=0, no SAT read.
REQ-044 start pulsed during RD_LOCK, then rst=0 for one cycle during GAP -> the second start is ignored; after reset all outputs are 0 and the next start runs the full sequence from WR_DIS.
REQ-045 max_polls=0, lock=0 -> exactly one lock read, then timeout=1.
